cpu_regs_wb_arbiter: RTL and testbench

//  Two-master Wishbone arbiter sharing the CPU internal register bank (PSW, stack limit, PIRQ, CER, CCR, ...,
//  17 777 740-776) between the CPU data port (M0) and the console/debug port (M1).

---
 rtl/cpu_regs_wb_arbiter_pkg.sv | 16 +
 rtl/cpu_regs_arb_timer.sv | 54 +++++
 rtl/cpu_regs_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_cpu_regs_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regs_wb_arbiter_pkg.sv
// Shared definitions for the CPU register-bank Wishbone arbiter.
package cpu_regs_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam int M_CPU = 0;
    localparam int M_CON = 1;

    localparam int ADR_W = 5;
    localparam int DAT_W = 16;

endpackage

// File: rtl/cpu_regs_arb_timer.sv
// Ack watchdog: counts unacknowledged strobe cycles, flags timeout and emits a one-cycle error.
module cpu_regs_arb_timer
    import cpu_regs_wb_arbiter_pkg::*;
#(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr_i,
    input  logic stb_i,
    input  logic ack_i,
    output logic tmo_o,
    output logic err_o
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
    logic          err;

    // Ack in the expiry cycle beats the timeout.
    assign err = stb_i & ~ack_i & (tcnt_q == TC_LAST);

    always_comb begin
        tcnt_d = tcnt_q;
        tmo_d  = tmo_q;
        if (clr_i) begin
            tcnt_d = '0;
            tmo_d  = 1'b0;
        end else if (ack_i) begin
            tcnt_d = '0;
        end else if (err) begin
            tmo_d = 1'b1;
        end else if (stb_i) begin
            tcnt_d = tcnt_q + CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign tmo_o = tmo_q;
    assign err_o = err;

endmodule

// File: rtl/cpu_regs_wb_arbiter.sv
// Two-master Wishbone arbiter for the CPU register bank: M0 (CPU) priority,
// M1 (console) anti-starvation escalation, ack timeout returning err.
module cpu_regs_wb_arbiter
    import cpu_regs_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int ACK_TIMEOUT  = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic             m0_we_i,
    input  logic [1:0]       m0_sel_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic             m1_we_i,
    input  logic [1:0]       m1_sel_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [DAT_W-1:0] m_dat_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             s_we_o,
    output logic [1:0]       s_sel_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic [1:0]       gnt_o
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [WW-1:0] wait1_q, wait1_d;
    logic [1:0]    gnt;
    logic          starve;
    logic          sel_cyc, sel_stb;
    logic          tmo, tmo_err;
    logic          grant_chg;

    assign gnt[M_CPU] = (state_q == ST_GNT0);
    assign gnt[M_CON] = (state_q == ST_GNT1);
    assign starve     = (wait1_q == WAIT_MAX);
    assign grant_chg  = (state_d != state_q);

    // Every release passes through IDLE, so a new grant always costs one idle cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (starve && m1_cyc_i)  state_d = ST_GNT1;
                else if (m0_cyc_i)       state_d = ST_GNT0;
                else if (m1_cyc_i)       state_d = ST_GNT1;
            end
            ST_GNT0: if (!m0_cyc_i) state_d = ST_IDLE;
            ST_GNT1: if (!m1_cyc_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait1_d = wait1_q;
        if (!m1_cyc_i || (state_d == ST_GNT1 && state_q != ST_GNT1)) begin
            wait1_d = '0;
        end else if (!gnt[M_CON] && !starve) begin
            wait1_d = wait1_q + WW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            wait1_q <= '0;
        end else begin
            state_q <= state_d;
            wait1_q <= wait1_d;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        if (gnt[M_CPU]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            sel_cyc = m0_cyc_i;
            sel_stb = m0_stb_i;
        end else if (gnt[M_CON]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            sel_cyc = m1_cyc_i;
            sel_stb = m1_stb_i;
        end
    end

    assign s_cyc_o = sel_cyc & ~tmo;
    assign s_stb_o = sel_stb & ~tmo;

    cpu_regs_arb_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .clr_i   (grant_chg),
        .stb_i   (s_cyc_o & s_stb_o),
        .ack_i   (s_ack_i),
        .tmo_o   (tmo),
        .err_o   (tmo_err)
    );

    assign m0_ack_o = s_ack_i & gnt[M_CPU];
    assign m1_ack_o = s_ack_i & gnt[M_CON];
    assign m0_err_o = tmo_err & gnt[M_CPU];
    assign m1_err_o = tmo_err & gnt[M_CON];
    assign m_dat_o  = s_dat_i;
    assign gnt_o    = gnt;

endmodule

// File: tb/tb_cpu_regs_wb_arbiter.sv
// Directed bench for cpu_regs_wb_arbiter with a per-cycle ownership model and a simple acking slave.
module tb_cpu_regs_wb_arbiter;

    localparam int STARVE_LIMIT = 16;
    localparam int ACK_TIMEOUT  = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [4:0]  m0_adr_i, m1_adr_i;
    logic [15:0] m0_dat_i, m1_dat_i;
    logic        m0_we_i, m1_we_i;
    logic [1:0]  m0_sel_i, m1_sel_i;
    logic        m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [15:0] m_dat_o, s_dat_o, s_dat_i;
    logic [4:0]  s_adr_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]  s_sel_o, gnt_o;

    cpu_regs_wb_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave: read-only bank, acks one cycle after cyc&stb, never twice in a row.
    logic [15:0] bank [16];
    logic        ack_q;
    logic        ack_en;
    assign s_ack_i = ack_q;
    assign s_dat_i = bank[s_adr_o[4:1]];

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) ack_q <= 1'b0;
        else          ack_q <= ack_en && s_cyc_o && s_stb_o && !ack_q;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: owner -1 idle, 0 CPU, 1 console.
    int owner  = -1;
    int waited = 0;
    int pend   = 0;
    bit tmo    = 1'b0;

    initial begin : model
        logic        e_cyc, e_stb, e_we, t_now, raw_cyc;
        logic [4:0]  e_adr;
        logic [15:0] e_dat;
        logic [1:0]  e_sel, e_gnt;
        int          nxt;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                owner = -1; waited = 0; pend = 0; tmo = 1'b0;
                chk("rst_gnt", gnt_o, 2'b00);
                chk("rst_s_cyc", s_cyc_o, 1'b0);
                chk("rst_s_stb", s_stb_o, 1'b0);
                chk("rst_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
            end else begin
                e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
                raw_cyc = 1'b0;
                if (owner == 0) begin
                    raw_cyc = m0_cyc_i; e_cyc = m0_cyc_i & !tmo; e_stb = m0_stb_i & !tmo;
                    e_adr = m0_adr_i; e_dat = m0_dat_i; e_we = m0_we_i; e_sel = m0_sel_i;
                end else if (owner == 1) begin
                    raw_cyc = m1_cyc_i; e_cyc = m1_cyc_i & !tmo; e_stb = m1_stb_i & !tmo;
                    e_adr = m1_adr_i; e_dat = m1_dat_i; e_we = m1_we_i; e_sel = m1_sel_i;
                end
                e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
                t_now = e_cyc && e_stb && !s_ack_i && (pend == ACK_TIMEOUT - 1);

                chk("gnt", gnt_o, e_gnt);
                chk("s_cyc", s_cyc_o, e_cyc);
                chk("s_stb", s_stb_o, e_stb);
                chk("s_adr", s_adr_o, e_adr);
                chk("s_dat", s_dat_o, e_dat);
                chk("s_we", s_we_o, e_we);
                chk("s_sel", s_sel_o, e_sel);
                chk("m0_ack", m0_ack_o, s_ack_i && owner == 0);
                chk("m1_ack", m1_ack_o, s_ack_i && owner == 1);
                chk("m0_err", m0_err_o, t_now && owner == 0);
                chk("m1_err", m1_err_o, t_now && owner == 1);
                chk("m_dat", m_dat_o, s_dat_i);

                if (owner < 0) begin
                    if (waited >= STARVE_LIMIT && m1_cyc_i) nxt = 1;
                    else if (m0_cyc_i)                      nxt = 0;
                    else if (m1_cyc_i)                      nxt = 1;
                    else                                    nxt = -1;
                end else begin
                    nxt = raw_cyc ? owner : -1;
                end

                if (!m1_cyc_i || (owner != 1 && nxt == 1)) waited = 0;
                else if (owner != 1) waited = (waited < STARVE_LIMIT) ? waited + 1 : STARVE_LIMIT;

                if (nxt != owner) begin
                    pend = 0; tmo = 1'b0;
                end else if (s_ack_i) begin
                    pend = 0;
                end else if (t_now) begin
                    tmo = 1'b1;
                end else if (e_cyc && e_stb) begin
                    pend++;
                end
                owner = nxt;
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge wb_clk_i);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  first_stb, first_err, npulse, acks, grant_c;
        bit  cyc_low_ok, got, seen;

        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = 2'b11; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = 2'b11; m1_cyc_i = 0; m1_stb_i = 0;
        ack_en = 1'b1;
        for (int i = 0; i < 16; i++) bank[i] = 16'h1000 + 16'(i);
        bank[15] = 16'hA5C3;

        smp();
        chk("reset_gnt", gnt_o, 2'b00);
        chk("reset_s_cyc", s_cyc_o, 1'b0);
        tick(); wb_rst_i = 1'b0;
        tick();

        // M0 read of word 15
        m0_adr_i = 5'b11110; m0_we_i = 0; m0_sel_i = 2'b11; m0_cyc_i = 1; m0_stb_i = 1;
        smp(); chk("t2_idle_gnt", gnt_o, 2'b00); chk("t2_idle_stb", s_stb_o, 1'b0);
        tick(); smp(); chk("t2_gnt0", gnt_o, 2'b01); chk("t2_stb", s_stb_o, 1'b1);
        chk("t2_adr", s_adr_o, 5'b11110); chk("t2_no_ack_yet", m0_ack_o, 1'b0);
        tick(); smp(); chk("t2_ack", m0_ack_o, 1'b1); chk("t2_rdata", m_dat_o, 16'hA5C3);
        chk("t2_m1_ack", m1_ack_o, 1'b0);
        tick(); m0_cyc_i = 0; m0_stb_i = 0;
        smp(); chk("t2_hold_gnt", gnt_o, 2'b01); chk("t2_cyc_drop", s_cyc_o, 1'b0);
        tick(); smp(); chk("t2_release", gnt_o, 2'b00);

        // Simultaneous requests: M0 first, M1 after one idle cycle
        tick();
        m0_adr_i = 5'b00010; m0_cyc_i = 1; m0_stb_i = 1;
        m1_adr_i = 5'b00100; m1_we_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
        smp(); chk("t3_idle", gnt_o, 2'b00);
        tick(); smp(); chk("t3_gnt0", gnt_o, 2'b01); chk("t3_m1_wait", m1_ack_o, 1'b0);
        tick(); smp(); chk("t3_m0_ack", m0_ack_o, 1'b1); chk("t3_m0_data", m_dat_o, 16'h1001);
        tick(); m0_cyc_i = 0; m0_stb_i = 0;
        smp(); chk("t3_gnt0_tail", gnt_o, 2'b01);
        tick(); smp(); chk("t3_idle_gap", gnt_o, 2'b00);
        tick(); smp(); chk("t3_gnt1", gnt_o, 2'b10);
        tick(); smp(); chk("t3_m1_ack", m1_ack_o, 1'b1); chk("t3_m1_data", m_dat_o, 16'h1002);
        tick(); m1_cyc_i = 0; m1_stb_i = 0;
        smp();
        tick(); smp(); chk("t3_release", gnt_o, 2'b00);

        // Starvation: M0 re-requests every 4 cycles, M1 holds cyc
        tick();
        m1_adr_i = 5'b00110; m1_cyc_i = 1; m1_stb_i = 1;
        m0_adr_i = 5'b01000; m0_cyc_i = 1; m0_stb_i = 1;
        got = 0; grant_c = -1;
        for (int c = 0; c < 80 && !got; c++) begin
            smp();
            if (gnt_o == 2'b10) begin
                got = 1; grant_c = c;
                chk("t4_m0_still_req", m0_cyc_i, 1'b1);
            end else begin
                seen = m0_ack_o;
                tick();
                if (seen) begin m0_cyc_i = 0; m0_stb_i = 0; end
                else if (!m0_cyc_i) begin m0_cyc_i = 1; m0_stb_i = 1; end
            end
        end
        chk("t4_granted", got, 1'b1);
        chk("t4_grant_cycle", grant_c, 32'd17);
        tick(); m0_cyc_i = 0; m0_stb_i = 0;
        smp(); chk("t4_m1_ack", m1_ack_o, 1'b1);
        tick(); m1_cyc_i = 0; m1_stb_i = 0;
        smp();
        tick(); smp(); chk("t4_release", gnt_o, 2'b00);

        // Timeout with slave never acking
        ack_en = 1'b0;
        tick();
        m0_adr_i = 5'b00000; m0_cyc_i = 1; m0_stb_i = 1;
        first_stb = -1; first_err = -1; npulse = 0; cyc_low_ok = 1;
        for (int c = 0; c < 20; c++) begin
            smp();
            if (s_stb_o && first_stb < 0) first_stb = c;
            if (m0_err_o) begin
                npulse++;
                if (first_err < 0) first_err = c;
            end
            if (first_err >= 0 && c > first_err && s_cyc_o) cyc_low_ok = 0;
            if (c < 19) tick();
        end
        chk("t5_first_stb", first_stb, 32'd1);
        chk("t5_err_delay", first_err - first_stb, 32'd7);
        chk("t5_err_pulses", npulse, 32'd1);
        chk("t5_cyc_suppressed", cyc_low_ok, 1'b1);
        chk("t5_grant_held", gnt_o, 2'b01);
        tick(); m0_cyc_i = 0; m0_stb_i = 0;
        smp();
        tick(); smp(); chk("t5_release", gnt_o, 2'b00);
        ack_en = 1'b1;

        // M1 write to CER
        tick();
        m1_adr_i = 5'b10110; m1_dat_i = 16'h5A3C; m1_we_i = 1; m1_sel_i = 2'b01;
        m1_cyc_i = 1; m1_stb_i = 1;
        acks = 0;
        smp(); chk("t6_idle", gnt_o, 2'b00);
        tick(); smp(); chk("t6_gnt1", gnt_o, 2'b10);
        chk("t6_adr", s_adr_o, 5'b10110); chk("t6_dat", s_dat_o, 16'h5A3C);
        chk("t6_sel", s_sel_o, 2'b01); chk("t6_we", s_we_o, 1'b1);
        acks += int'(m1_ack_o);
        tick(); smp(); acks += int'(m1_ack_o); chk("t6_m0_ack", m0_ack_o, 1'b0);
        tick(); m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        smp(); acks += int'(m1_ack_o);
        tick(); smp(); acks += int'(m1_ack_o); chk("t6_release", gnt_o, 2'b00);
        chk("t6_ack_count", acks, 32'd1);

        // Reset asserted in the middle of a granted cycle
        tick();
        m0_adr_i = 5'b00100; m0_cyc_i = 1; m0_stb_i = 1;
        smp();
        tick(); smp(); chk("t1_pre_gnt", gnt_o, 2'b01);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("t1_gnt", gnt_o, 2'b00);
        chk("t1_s_cyc", s_cyc_o, 1'b0);
        chk("t1_s_stb", s_stb_o, 1'b0);
        chk("t1_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
        tick(); m0_cyc_i = 0; m0_stb_i = 0;
        tick(); wb_rst_i = 1'b0;
        smp(); chk("t1_after", gnt_o, 2'b00);
        tick(); smp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
